// File: rtl/cpu_pkg.sv
// Shared fetch definitions: FSM states, instruction size encodings, opcode size field.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    ISSUE   = 2'd2,
    ADVANCE = 2'd3
  } fetch_state_e;

  localparam logic [1:0] SIZE_1 = 2'd1;
  localparam logic [1:0] SIZE_2 = 2'd2;
  localparam logic [1:0] SIZE_3 = 2'd3;

  // Instruction length lives in opcode[7:6].
  localparam int OPC_SIZE_HI = 7;
  localparam int OPC_SIZE_LO = 6;

  // 00 -> 1 byte, 01 -> 2 bytes, 10 -> 3 bytes, 11 -> 1 byte.
  function automatic logic [1:0] instr_size_from_opcode(input logic [7:0] opc);
    logic [1:0] fld;
    fld = opc[OPC_SIZE_HI:OPC_SIZE_LO];
    case (fld)
      2'b00:   return SIZE_1;
      2'b01:   return SIZE_2;
      2'b10:   return SIZE_3;
      default: return SIZE_1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_size_decode.sv
// Combinational opcode -> instruction size (1..3).
module fetch_size_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] size
);

  assign size = instr_size_from_opcode(opcode);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads 1..3 opcode bytes at pc, hands them to
// decode over valid/ready, then releases the PC for exactly one step.
// Optional perf counters (instr_count, stall_cycles) with FETCH_PERF_CNT_EN.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  adv,
  output logic                  jump_en,
  output logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [1:0]            instr_size,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_opcode,
  output logic [DATA_WIDTH-1:0] instr_op1,
  output logic [DATA_WIDTH-1:0] instr_op2,
  input  logic                  jump_req,
  input  logic [ADDR_WIDTH-1:0] jump_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]           instr_count,
  output logic [15:0]           stall_cycles
`endif
);

  fetch_state_e state;
  logic [1:0]   idx;
  logic [1:0]   dec_size;
  logic [1:0]   cur_size;

  fetch_size_decode u_size (
    .opcode (mem_rdata),
    .size   (dec_size)
  );

  // Byte 0 defines the length; later bytes use the size already latched.
  assign cur_size = (idx == 2'd0) ? dec_size : instr_size;

  // Main FSM. mem_rd is raised on entry to FETCH so a read goes out in the
  // first FETCH cycle; mem_addr for the post-ADVANCE fetch is computed from the
  // same next-PC rule program_counter applies on that edge. Out of reset,
  // FETCH spends one cycle priming the strobe from the live pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      idx          <= 2'd0;
      adv          <= 1'b1;
      jump_en      <= 1'b0;
      jump_addr    <= '0;
      instr_size   <= SIZE_1;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      instr_valid  <= 1'b0;
      instr_opcode <= '0;
      instr_op1    <= '0;
      instr_op2    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_rd) begin
            mem_rd <= 1'b0;
            state  <= WAIT;
          end else begin
            mem_rd   <= 1'b1;
            mem_addr <= pc + ADDR_WIDTH'(idx);
          end
        end
        WAIT: begin
          if (mem_ready) begin
            case (idx)
              2'd0: begin
                instr_opcode <= mem_rdata;
                instr_op1    <= '0;
                instr_op2    <= '0;
                instr_size   <= dec_size;
              end
              2'd1:    instr_op1 <= mem_rdata;
              default: instr_op2 <= mem_rdata;
            endcase
            if (({1'b0, idx} + 3'd1) < {1'b0, cur_size}) begin
              idx      <= idx + 2'd1;
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr + ADDR_WIDTH'(1);
              state    <= FETCH;
            end else begin
              instr_valid <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            jump_en     <= jump_req;
            jump_addr   <= jump_target;
            adv         <= 1'b0;
            state       <= ADVANCE;
          end
        end
        ADVANCE: begin
          adv      <= 1'b1;
          jump_en  <= 1'b0;
          idx      <= 2'd0;
          mem_rd   <= 1'b1;
          mem_addr <= jump_en ? jump_addr : pc + ADDR_WIDTH'(instr_size);
          state    <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating handshake and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == ISSUE && instr_ready && instr_count != 16'hFFFF)
        instr_count <= instr_count + 16'd1;
      if (((state == WAIT && !mem_ready) || (state == ISSUE && !instr_ready))
          && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: models program_counter and a byte memory
// with programmable latency, checks outputs on the falling edge.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc;
  logic       adv, jump_en, mem_rd, instr_valid;
  logic [7:0] jump_addr, mem_addr, instr_opcode, instr_op1, instr_op2;
  logic [1:0] instr_size;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic       instr_ready = 1'b1;
  logic       jump_req = 1'b0;
  logic [7:0] jump_target = 8'h00;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] instr_count, stall_cycles;
`endif

  logic [7:0] mem [256];
  logic [7:0] pc_init = 8'h00;
  int         lat = 1;
  int         cnt = 0;
  logic [7:0] paddr = 8'h00;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .adv          (adv),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .instr_size   (instr_size),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_op1    (instr_op1),
    .instr_op2    (instr_op2),
    .jump_req     (jump_req),
    .jump_target  (jump_target)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instr_count  (instr_count),
    .stall_cycles (stall_cycles)
`endif
  );

  // program_counter model: loads pc_init on reset, steps when adv=0.
  always @(posedge clk) begin
    if (rst) pc <= pc_init;
    else if (!adv) pc <= jump_en ? jump_addr : pc + 8'(instr_size);
  end

  // Memory: ready pulses 'lat' cycles after mem_rd; not reset-aware, so an
  // outstanding read can complete after a reset.
  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (mem_rd) begin
      if (lat == 1) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[mem_addr];
      end else begin
        cnt   <= lat - 1;
        paddr <= mem_addr;
      end
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[paddr];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] p);
    rst = 1'b1;
    pc_init = p;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for the next read strobe, then check its address.
  task automatic wait_rd(input string tag, input logic [7:0] a);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mem_rd) break;
    end
    chk(tag, 32'({mem_rd, mem_addr}), 32'({1'b1, a}));
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (instr_valid) break;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // ---- 1: reset values, 1-byte instruction, 4-cycle issue interval
    mem[0] = 8'h05;
    mem[1] = 8'h00;
    lat = 1;
    instr_ready = 1'b1;
    rst = 1'b1;
    pc_init = 8'h00;
    tick();
    tick();
    chk("rst_ctl", 32'({adv, jump_en, mem_rd, instr_valid, instr_size}), 32'({4'b1000, 2'd1}));
    chk("rst_addr", 32'({jump_addr, mem_addr}), 32'h0);
    chk("rst_bytes", 32'({instr_opcode, instr_op1, instr_op2}), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf", 32'({instr_count, stall_cycles}), 32'h0);
`endif
    rst = 1'b0;
    tick();
    chk("t1_rd0", 32'({mem_rd, mem_addr}), 32'({1'b1, 8'h00}));
    tick();
    chk("t1_wait", 32'({mem_rd, instr_valid}), 32'b00);
    tick();
    chk("t1_issue", 32'({instr_valid, adv, instr_size, instr_opcode, instr_op1, instr_op2}),
        32'({1'b1, 1'b1, 2'd1, 8'h05, 8'h00, 8'h00}));
    tick();
    chk("t1_adv", 32'({adv, instr_valid, jump_en}), 32'b000);
    tick();
    chk("t1_rd1", 32'({mem_rd, mem_addr, adv}), 32'({1'b1, 8'h01, 1'b1}));
    tick();
    chk("t1_gap", 32'(instr_valid), 32'd0);
    tick();
    chk("t1_issue2", 32'({instr_valid, instr_opcode}), 32'({1'b1, 8'h00}));

    // ---- 2: 3-byte at 0x10, then a 1-byte clears stale operands
    mem[8'h10] = 8'h90; mem[8'h11] = 8'hAA; mem[8'h12] = 8'hBB; mem[8'h13] = 8'h07;
    do_reset(8'h10);
    wait_rd("t2_rd10", 8'h10);
    wait_rd("t2_rd11", 8'h11);
    wait_rd("t2_rd12", 8'h12);
    wait_valid("t2_valid");
    chk("t2_bytes", 32'({instr_size, instr_opcode, instr_op1, instr_op2}),
        32'({2'd3, 8'h90, 8'hAA, 8'hBB}));
    tick();
    chk("t2_adv", 32'({adv, jump_en}), 32'b00);
    wait_rd("t2_rd13", 8'h13);
    wait_valid("t2_valid2");
    chk("t2_zeroed", 32'({instr_size, instr_opcode, instr_op1, instr_op2}),
        32'({2'd1, 8'h07, 8'h00, 8'h00}));

    // ---- 3: address wrap
    mem[8'hFE] = 8'h80; mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22;
    do_reset(8'hFE);
    wait_rd("t3_rdFE", 8'hFE);
    wait_rd("t3_rdFF", 8'hFF);
    wait_rd("t3_rd00", 8'h00);
    wait_valid("t3_valid");
    chk("t3_bytes", 32'({instr_size, instr_opcode, instr_op1, instr_op2}),
        32'({2'd3, 8'h80, 8'h11, 8'h22}));
    wait_rd("t3_rd01", 8'h01);

    // ---- 4: 2-byte with jump on the handshake
    mem[8'h20] = 8'h41; mem[8'h21] = 8'h77;
    jump_req = 1'b1;
    jump_target = 8'h40;
    do_reset(8'h20);
    wait_rd("t4_rd20", 8'h20);
    wait_rd("t4_rd21", 8'h21);
    wait_valid("t4_valid");
    chk("t4_bytes", 32'({instr_size, instr_opcode, instr_op1, instr_op2}),
        32'({2'd2, 8'h41, 8'h77, 8'h00}));
    tick();
    chk("t4_adv", 32'({adv, jump_en, jump_addr}), 32'({1'b0, 1'b1, 8'h40}));
    tick();
    jump_req = 1'b0;
    chk("t4_rd40", 32'({mem_rd, mem_addr, jump_en, pc}), 32'({1'b1, 8'h40, 1'b0, 8'h40}));

    // ---- 5: 3-cycle memory, decode stalls 5 cycles
    mem[8'h30] = 8'h45; mem[8'h31] = 8'h99;
    lat = 3;
    instr_ready = 1'b0;
    do_reset(8'h30);
    wait_rd("t5_rd30", 8'h30);
    wait_rd("t5_rd31", 8'h31);
    wait_valid("t5_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold", 32'({instr_valid, adv, instr_size, instr_opcode, instr_op1, instr_op2}),
          32'({1'b1, 1'b1, 2'd2, 8'h45, 8'h99, 8'h00}));
    end
    instr_ready = 1'b1;
    tick();
    chk("t5_adv", 32'({adv, instr_valid}), 32'b00);
`ifdef FETCH_PERF_CNT_EN
    chk("t5_perf", 32'({instr_count, stall_cycles}), 32'({16'd1, 16'd9}));
`endif
    wait_rd("t5_rd32", 8'h32);

    // ---- 6: reset during WAIT of byte 2, stale ready afterwards
    mem[8'h00] = 8'h41; mem[8'h01] = 8'h5A;
    lat = 3;
    do_reset(8'h00);
    wait_rd("t6_rd00", 8'h00);
    wait_rd("t6_rd01", 8'h01);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst", 32'({mem_rd, mem_addr, instr_valid, instr_size, instr_opcode}),
        32'({1'b0, 8'h00, 1'b0, 2'd1, 8'h00}));
    rst = 1'b0;
    tick();
    chk("t6_restart", 32'({mem_ready, mem_rd, mem_addr, instr_valid}),
        32'({1'b1, 1'b1, 8'h00, 1'b0}));
    wait_rd("t6_rd01b", 8'h01);
    wait_valid("t6_valid");
    chk("t6_bytes", 32'({instr_size, instr_opcode, instr_op1, instr_op2}),
        32'({2'd2, 8'h41, 8'h5A, 8'h00}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the program counter.
- Reads a 1-, 2- or 3-byte instruction from byte-wide memory starting at the current PC and presents it to decode with a valid/ready handshake.
- Then releases the PC for exactly one step, either sequential by instruction size or a jump.
- Sits between program_counter, the instruction memory port and the decode/execute stage.

Parameters:
- ADDR_WIDTH, 8, PC and memory address width.
- DATA_WIDTH, 8, memory data / opcode width; fixed at 8, any other value is unsupported.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- pc  in  ADDR_WIDTH  current PC value from program_counter.
- adv  out  1  PC hold: 1 = hold PC, 0 = PC updates this edge (program_counter convention).
- jump_en  out  1  to program_counter; meaningful only when adv=0.
- jump_addr  out  ADDR_WIDTH  jump target to program_counter.
- instr_size  out  2  size of current instruction, 1..3, to program_counter and decode.
- mem_rd  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_WIDTH  read address; stable from the mem_rd cycle until mem_ready.
- mem_rdata  in  8  read data; valid when mem_ready=1.
- mem_ready  in  1  read complete; earliest one cycle after mem_rd.
- instr_valid  out  1  instruction bytes valid to decode.
- instr_ready  in  1  decode accepts.
- instr_opcode  out  8  byte at PC.
- instr_op1  out  8  byte at PC+1; 0 when size<2.
- instr_op2  out  8  byte at PC+2; 0 when size<3.
- jump_req  in  1  decode/execute requests a jump for the accepted instruction.
- jump_target  in  ADDR_WIDTH  target address; sampled with jump_req.

Behaviour:
- Reset values: state=FETCH, byte index=0, adv=1, jump_en=0, jump_addr=0, instr_size=1, mem_rd=0, mem_addr=0, instr_valid=0, opcode/op1/op2=0.
- FETCH:
  - Assert mem_rd for one cycle with mem_addr = pc + idx, where idx is 0..2.
  - The addition wraps mod 2^ADDR_WIDTH (pc=0xFF, idx=1 gives 0x00).
  - Go to WAIT.
- WAIT:
  - Hold mem_addr, mem_rd=0.
  - On mem_ready, capture mem_rdata into the byte slot for idx.
  - If idx=0, decode size from opcode[7:6]: 00->1, 01->2, 10->3, 11->1.
  - If idx+1 < size, then idx++ and go to FETCH; otherwise go to ISSUE.
- ISSUE:
  - instr_valid=1; opcode, op1, op2 and size are held stable until the handshake.
  - Handshake is instr_valid && instr_ready. On that cycle, latch jump_req into jump_en and jump_target into jump_addr, then go to ADVANCE.
- ADVANCE:
  - Exactly one cycle: adv=0, instr_valid=0.
  - PC updates on this edge, either to jump_addr or to pc + instr_size.
  - Clear idx, go to FETCH.
  - jump_en clears to 0 on the following cycle.
- adv=1 in every state except ADVANCE; the PC never moves while bytes are being fetched.
- Latency: minimum issue-to-issue is 4 cycles for a 1-byte instruction with 1-cycle memory, and 8 cycles for a 3-byte instruction.
- mem_ready arriving outside WAIT (stale response after reset) is ignored.
- jump_req outside the handshake cycle is ignored.
- Simultaneous handshake and jump_req: the jump wins and sequential advance is suppressed.
- rst mid-operation (any state): return to reset values on the next edge; partial bytes are discarded and any outstanding read is abandoned.
- Unused operand slots are zeroed on every new opcode capture.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro: two extra outputs.
  - instr_count[15:0] increments on each handshake.
  - stall_cycles[15:0] increments on each cycle in WAIT with mem_ready=0, or in ISSUE with instr_ready=0.
  - Both saturate at 0xFFFF and clear on rst.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (FETCH, WAIT, ISSUE, ADVANCE);
  - size encodings SIZE_1, SIZE_2, SIZE_3;
  - the opcode size field position [7:6];
  - the instr_size_from_opcode function.
- One sub-module: fetch_size_decode, purely combinational, opcode to size.
- The FSM and byte registers stay in fetch_sequencer.

Test Plan:
- Reset, then memory[0]=0x05 (1-byte), 1-cycle memory, instr_ready=1 -> one read at addr 0x00, opcode=0x05, op1=op2=0, size=1, adv=0 for one cycle, next read at 0x01.
- pc=0x10, bytes 0x90,0xAA,0xBB (3-byte) -> reads at 0x10,0x11,0x12, op1=0xAA, op2=0xBB, size=3, next fetch address 0x13.
- pc=0xFE, opcode 0x80 (3-byte) -> reads 0xFE, 0xFF, 0x00 (wrap), then next fetch at 0x01.
- 2-byte instruction with jump_req=1 and jump_target=0x40 on the handshake -> ADVANCE has adv=0, jump_en=1, jump_addr=0x40; next read at 0x40.
- instr_ready held 0 for 5 cycles, then mem latency of 3 cycles -> instr_valid and bytes stable throughout; adv=1 until the handshake; with FETCH_PERF_CNT_EN, stall_cycles grows by the stall count.
- rst asserted in WAIT of the 2nd byte, with mem_ready arriving one cycle after rst deasserts -> response ignored; fetch restarts at pc=0x00 with idx=0.
